vga_fb_arbiter: RTL



---
 rtl/vga_pkg.sv | 28 ++
 rtl/fb_addr_gen.sv | 33 +++
 rtl/vga_fb_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants and slot-phase encoding for the VGA framebuffer arbiter.
// Defining DBUF_EN widens the RAM address by one bank bit.
package vga_pkg;

    localparam int FB_W        = 160;
    localparam int FB_H        = 120;
    localparam int SCALE_SHIFT = 2;
    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 15;
`ifdef DBUF_EN
    localparam int BA_W        = ADDR_W + 1;
`else
    localparam int BA_W        = ADDR_W;
`endif

    typedef enum logic [1:0] {
        PH_RD  = 2'd0,
        PH_CAP = 2'd1,
        PH_W0  = 2'd2,
        PH_W1  = 2'd3
    } phase_e;

    // Phase advances once per clock and parks in the last writer slot.
    function automatic phase_e phase_adv(input phase_e ph);
        return (ph == PH_W1) ? PH_W1 : phase_e'(ph + 2'd1);
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Screen coordinate to framebuffer word address: (y>>s)*FB_W + (x>>s),
// built as a shift-and-add over the set bits of FB_W (128+32 for 160).
module fb_addr_gen
    import vga_pkg::*;
(
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int NB = $clog2(FB_W + 1);

    logic [ADDR_W-1:0] xs;
    logic [ADDR_W-1:0] ys;
    logic [ADDR_W-1:0] part [0:NB];

    assign xs      = ADDR_W'(x_i >> SCALE_SHIFT);
    assign ys      = ADDR_W'(y_i >> SCALE_SHIFT);
    assign part[0] = xs;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_mul
            if (((FB_W >> gi) & 1) != 0) begin : g_add
                assign part[gi+1] = part[gi] + (ys << gi);
            end else begin : g_pass
                assign part[gi+1] = part[gi];
            end
        end
    endgenerate

    assign addr_o = part[NB];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: one display read slot per pixel, writer gets the rest.
// Define DBUF_EN for double buffering with frame-synchronous bank swap.
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic              CLK_100MHz,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [BA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rgb,
    input  logic              swap_req,
    output logic              swap_done
);

    phase_e            phase_q, phase_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] pix_buf_q, pix_buf_d;
    logic [DATA_W-1:0] rgb_q, rgb_d;
    logic              rd_slot, wr_slot;
    logic [ADDR_W-1:0] rd_addr;
    logic [BA_W-1:0]   rd_full, wr_full;

    fb_addr_gen u_addr (
        .x_i    (pixel_x),
        .y_i    (pixel_y),
        .addr_o (rd_addr)
    );

    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            phase_q   <= PH_W1;
            rd_pend_q <= 1'b0;
            pix_buf_q <= '0;
            rgb_q     <= '0;
        end else begin
            phase_q   <= phase_d;
            rd_pend_q <= rd_pend_d;
            pix_buf_q <= pix_buf_d;
            rgb_q     <= rgb_d;
        end
    end

    always_comb begin
        phase_d   = pix_en ? PH_RD : phase_adv(phase_q);
        rd_pend_d = rd_pend_q;
        pix_buf_d = pix_buf_q;
        if (phase_q == PH_CAP) begin
            pix_buf_d = rd_pend_q ? mem_rdata : '0;
            rd_pend_d = 1'b0;
        end
        if (rd_slot) begin
            rd_pend_d = 1'b1;
        end
        rgb_d = pix_en ? pix_buf_q : rgb_q;
    end

    // Slot decode is gated by reset so no RAM access leaks out during reset.
    always_comb begin
        rd_slot = 1'b0;
        wr_slot = 1'b0;
        if (!reset) begin
            case (phase_q)
                PH_RD: begin
                    rd_slot = video_on;
                    wr_slot = !video_on;
                end
                PH_CAP:  wr_slot = 1'b0;
                default: wr_slot = 1'b1;
            endcase
        end
        wr_ack    = wr_slot & wr_req;
        mem_en    = rd_slot | wr_ack;
        mem_we    = wr_ack;
        mem_wdata = wr_data;
        mem_addr  = '0;
        if (rd_slot) begin
            mem_addr = rd_full;
        end else if (wr_ack) begin
            mem_addr = wr_full;
        end
    end

    assign rgb = rgb_q;

`ifdef DBUF_EN
    logic disp_bank_q, disp_bank_d;
    logic swap_pend_q, swap_pend_d;
    logic swap_done_q, swap_done_d;
    logic frame_start;

    assign frame_start = pix_en && (pixel_x == 10'd0) && (pixel_y == 10'd0);

    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            disp_bank_q <= 1'b0;
            swap_pend_q <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            disp_bank_q <= disp_bank_d;
            swap_pend_q <= swap_pend_d;
            swap_done_q <= swap_done_d;
        end
    end

    // A request coinciding with frame start is folded in before the swap test.
    always_comb begin
        disp_bank_d = disp_bank_q;
        swap_pend_d = swap_pend_q | swap_req;
        swap_done_d = 1'b0;
        if (frame_start && swap_pend_d) begin
            disp_bank_d = ~disp_bank_q;
            swap_pend_d = 1'b0;
            swap_done_d = 1'b1;
        end
    end

    assign rd_full   = {disp_bank_q, rd_addr};
    assign wr_full   = {~disp_bank_q, wr_addr};
    assign swap_done = swap_done_q;
`else
    logic unused_swap;
    assign unused_swap = swap_req;
    assign rd_full     = rd_addr;
    assign wr_full     = wr_addr;
    assign swap_done   = 1'b0;
`endif

endmodule
